// File: rtl/dr_link_tx.sv
// dr_link_tx -- dual-rail link transmitter.
//
// Takes binary words over a valid/ready handshake and drives them onto a
// delay-insensitive dual-rail link, then waits for the receiver's
// asynchronous acknowledge before offering the next word.
//   ENC = "FP" : four-phase return-to-zero; data, wait ack=1, spacer, wait ack=0.
//   ENC = "TP" : two-phase transition; one rail toggles per bit and each
//                complete word is acknowledged by one ack transition.
//
// Ports:
//   clk       sole clock, rising edge
//   rst       synchronous active-high reset
//   in_valid  word offered
//   in_ready  word can be accepted this cycle
//   in_data   binary word, sampled only on accept
//   dr_o      registered dual-rail link, [bit][rail], rail 1 = logical 1
//   ack_i     asynchronous acknowledge from the receiver
//   busy      transfer outstanding
//   timeout   sticky watchdog flag
//
// Optional feature: define DR_LINK_TX_TIMEOUT_EN to enable the watchdog
// (TIMEOUT_CYCLES, ERR state). Without it timeout is tied 0 and the block
// waits for ack indefinitely.
module dr_link_tx #(
    parameter       ENC            = "TP",
    parameter int   WIDTH          = 1,
    parameter int   SYNC_STAGES    = 2,
    parameter int   TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic [WIDTH-1:0][1:0] dr_o,
    input  logic                  ack_i,
    output logic                  busy,
    output logic                  timeout
);

    localparam bit IS_FP = (ENC == "FP");

    typedef logic [WIDTH-1:0][1:0] link_t;

`ifdef DR_LINK_TX_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, DATA, RTZ, ERR} state_t;
`else
    typedef enum logic [1:0] {IDLE, DATA, RTZ} state_t;
`endif

    state_t                 state;
    state_t                 state_nxt;
    logic                   phase;
    logic                   accept;
    logic                   link_clr;
    logic                   ack_s;
    logic                   ack_settled;
    logic [SYNC_STAGES-1:0] ack_sync;

    // Four-phase code word: exactly one rail high per bit.
    function automatic link_t fp_encode(input logic [WIDTH-1:0] d);
        link_t r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = d[i] ? 2'b10 : 2'b01;
        end
        return r;
    endfunction

    // Two-phase code word: toggle the rail selected by each bit's value.
    function automatic link_t tp_encode(input link_t cur, input logic [WIDTH-1:0] d);
        link_t r;
        r = cur;
        for (int i = 0; i < WIDTH; i++) begin
            r[i][d[i]] = ~cur[i][d[i]];
        end
        return r;
    endfunction

    // ---- ack synchroniser: ack_i is asynchronous, only ack_s is used ----
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_i};
        end
    end

    assign ack_s = ack_sync[SYNC_STAGES-1];

    // The receiver is ready for a new word once ack has returned to the
    // level matching the last word sent (0 for FP, the phase bit for TP).
    assign ack_settled = IS_FP ? !ack_s : (ack_s == phase);
    assign in_ready    = (state == IDLE) && !rst && ack_settled;
    assign busy        = (state != IDLE);

`ifdef DR_LINK_TX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wd_cnt;
    logic             wd_expired;
    logic             timeout_q;

    assign wd_expired = (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign timeout    = timeout_q;

    // ---- watchdog: counts cycles spent waiting on the receiver ----
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (accept) begin
                wd_cnt <= '0;
            end else if (state == DATA || state == RTZ) begin
                wd_cnt <= wd_cnt + CNT_W'(1);
            end
            if (state_nxt == ERR) begin
                timeout_q <= 1'b1;
            end
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // ---- next-state logic ----
    always_comb begin
        state_nxt = state;
        accept    = in_valid && in_ready;
        link_clr  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (IS_FP && ack_s) begin
                    state_nxt = RTZ;
                    link_clr  = 1'b1;
                end else if (!IS_FP && (ack_s == phase)) begin
                    state_nxt = IDLE;
`ifdef DR_LINK_TX_TIMEOUT_EN
                end else if (wd_expired) begin
                    state_nxt = ERR;
`endif
                end
            end
            RTZ: begin
                if (!ack_s) begin
                    state_nxt = IDLE;
`ifdef DR_LINK_TX_TIMEOUT_EN
                end else if (wd_expired) begin
                    state_nxt = ERR;
`endif
                end
            end
            default: begin
                // ERR holds until reset.
                state_nxt = state;
            end
        endcase
    end

    // ---- state, phase and link register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            phase <= 1'b0;
            dr_o  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                dr_o <= IS_FP ? fp_encode(in_data) : tp_encode(dr_o, in_data);
                if (!IS_FP) begin
                    phase <= ~phase;
                end
            end else if (link_clr) begin
                dr_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dr_link_tx.sv
module tb_dr_link_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           fp_valid, fp_ready, fp_ack, fp_busy, fp_timeout;
    logic [3:0]     fp_data;
    logic [3:0][1:0] fp_dr;
    logic           tp_valid, tp_ready, tp_ack, tp_busy, tp_timeout;
    logic [3:0]     tp_data;
    logic [3:0][1:0] tp_dr;

    dr_link_tx #(.ENC("FP"), .WIDTH(4), .SYNC_STAGES(2), .TIMEOUT_CYCLES(16)) u_fp (
        .clk(clk), .rst(rst), .in_valid(fp_valid), .in_ready(fp_ready),
        .in_data(fp_data), .dr_o(fp_dr), .ack_i(fp_ack), .busy(fp_busy),
        .timeout(fp_timeout)
    );

    dr_link_tx #(.ENC("TP"), .WIDTH(4), .SYNC_STAGES(2), .TIMEOUT_CYCLES(16)) u_tp (
        .clk(clk), .rst(rst), .in_valid(tp_valid), .in_ready(tp_ready),
        .in_data(tp_data), .dr_o(tp_dr), .ack_i(tp_ack), .busy(tp_busy),
        .timeout(tp_timeout)
    );

    typedef struct {
        logic [3:0] data;
        logic [7:0] fp_exp;
        logic [7:0] tp_exp;
    } vec_t;

    vec_t       vecs[4];
    logic [7:0] sb_q[$];
    int         errors = 0;
    int         checks = 0;
    int         fp_acc = 0;
    int         tp_acc = 0;
    int         fp_acc_exp = 0;
    int         tp_acc_exp = 0;

    always @(posedge clk) begin
        if (fp_valid && fp_ready) fp_acc <= fp_acc + 1;
        if (tp_valid && tp_ready) tp_acc <= tp_acc + 1;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_check(input string name, input logic [7:0] act);
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got %0h", name, act);
        end else begin
            chk(name, act, sb_q.pop_front());
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ready(input bit is_fp, input string tag);
        int w = 0;
        while (!(is_fp ? fp_ready : tp_ready) && w < 100) begin
            tick(1);
            w++;
        end
        chk({tag, " ready"}, is_fp ? fp_ready : tp_ready, 1);
    endtask

    // Four-phase transfer with in_valid held high and in_data churning while busy.
    task automatic fp_xfer(input logic [3:0] d, input logic [7:0] exp, input string tag);
        wait_ready(1'b1, tag);
        fp_valid = 1'b1;
        fp_data  = d;
        sb_q.push_back(exp);
        fp_acc_exp++;
        tick(1);
        fp_data = 4'($urandom);
        sb_check({tag, " dr"}, fp_dr);
        chk({tag, " busy"}, fp_busy, 1);
        fp_ack = 1'b1;
        tick(1);
        fp_data = 4'($urandom);
        tick(1);
        chk({tag, " dr_hold"}, fp_dr, exp);
        fp_data = 4'($urandom);
        tick(1);
        chk({tag, " dr_rtz"}, fp_dr, 0);
        fp_ack = 1'b0;
        tick(1);
        fp_data = 4'($urandom);
        tick(1);
        chk({tag, " ready_early"}, fp_ready, 0);
        tick(1);
        chk({tag, " ready_back"}, fp_ready, 1);
        chk({tag, " idle"}, fp_busy, 0);
        fp_valid = 1'b0;
    endtask

    // Two-phase transfer: one ack transition completes the word.
    task automatic tp_xfer(input logic [3:0] d, input logic [7:0] exp, input string tag);
        wait_ready(1'b0, tag);
        tp_valid = 1'b1;
        tp_data  = d;
        sb_q.push_back(exp);
        tp_acc_exp++;
        tick(1);
        tp_data = 4'($urandom);
        sb_check({tag, " dr"}, tp_dr);
        chk({tag, " busy"}, tp_busy, 1);
        tp_ack = ~tp_ack;
        tick(1);
        tp_data = 4'($urandom);
        tick(1);
        chk({tag, " ready_early"}, tp_ready, 0);
        chk({tag, " dr_hold"}, tp_dr, exp);
        tick(1);
        chk({tag, " ready_back"}, tp_ready, 1);
        chk({tag, " idle"}, tp_busy, 0);
        tp_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{4'b0011, 8'b01_01_10_10, 8'b01_01_10_10};
        vecs[1] = '{4'b0001, 8'b01_01_01_10, 8'b00_00_11_00};
        vecs[2] = '{4'b1111, 8'b10_10_10_10, 8'b10_10_01_10};
        vecs[3] = '{4'b1010, 8'b10_01_10_01, 8'b00_11_11_11};

        // Reset with in_valid asserted: nothing may be accepted.
        rst      = 1'b1;
        fp_valid = 1'b1;
        fp_data  = 4'hF;
        fp_ack   = 1'b0;
        tp_valid = 1'b1;
        tp_data  = 4'hF;
        tp_ack   = 1'b0;
        tick(3);
        chk("rst fp_dr", fp_dr, 0);
        chk("rst fp_ready", fp_ready, 0);
        chk("rst fp_busy", fp_busy, 0);
        chk("rst fp_timeout", fp_timeout, 0);
        chk("rst tp_dr", tp_dr, 0);
        chk("rst tp_ready", tp_ready, 0);
        chk("rst tp_busy", tp_busy, 0);
        chk("rst no_accept", fp_acc + tp_acc, 0);
        fp_valid = 1'b0;
        tp_valid = 1'b0;
        rst      = 1'b0;
        #1;
        chk("rel fp_ready", fp_ready, 1);
        chk("rel tp_ready", tp_ready, 1);

        // Four-phase table.
        for (int i = 0; i < 4; i++) begin
            fp_xfer(vecs[i].data, vecs[i].fp_exp, $sformatf("fp_vec%0d", i));
        end

        // Spurious ack while idle must block in_ready and cause no accept.
        fp_ack = 1'b1;
        tick(2);
        chk("spur ready_low", fp_ready, 0);
        fp_valid = 1'b1;
        fp_data  = 4'hF;
        tick(3);
        chk("spur busy", fp_busy, 0);
        chk("spur dr", fp_dr, 0);
        fp_valid = 1'b0;
        fp_ack   = 1'b0;
        tick(2);
        chk("spur ready_back", fp_ready, 1);

        // Reset in DATA abandons the word.
        wait_ready(1'b1, "midrst");
        fp_valid = 1'b1;
        fp_data  = 4'b1111;
        sb_q.push_back(8'b10_10_10_10);
        fp_acc_exp++;
        tick(1);
        fp_valid = 1'b0;
        sb_check("midrst dr", fp_dr);
        rst = 1'b1;
        tick(1);
        chk("midrst dr_zero", fp_dr, 0);
        chk("midrst busy", fp_busy, 0);
        chk("midrst ready", fp_ready, 0);
        rst = 1'b0;
        fp_xfer(4'b1010, 8'b10_01_10_01, "post_rst");

`ifdef DR_LINK_TX_TIMEOUT_EN
        // Watchdog: no ack, flag raised 16 cycles after accept, sticky until reset.
        wait_ready(1'b1, "wd");
        fp_valid = 1'b1;
        fp_data  = 4'b0110;
        sb_q.push_back(8'b01_10_10_01);
        fp_acc_exp++;
        tick(1);
        fp_valid = 1'b0;
        sb_check("wd dr", fp_dr);
        tick(15);
        chk("wd before", fp_timeout, 0);
        tick(1);
        chk("wd flag", fp_timeout, 1);
        chk("wd ready", fp_ready, 0);
        chk("wd busy", fp_busy, 1);
        chk("wd dr_held", fp_dr, 8'b01_10_10_01);
        fp_ack = 1'b1;
        tick(6);
        chk("wd sticky", fp_timeout, 1);
        chk("wd stuck", fp_busy, 1);
        fp_ack = 1'b0;
        rst    = 1'b1;
        tick(1);
        chk("wd rst_flag", fp_timeout, 0);
        chk("wd rst_busy", fp_busy, 0);
        rst = 1'b0;
`endif

        // Two-phase table.
        for (int i = 0; i < 4; i++) begin
            tp_xfer(vecs[i].data, vecs[i].tp_exp, $sformatf("tp_vec%0d", i));
        end

`ifndef DR_LINK_TX_TIMEOUT_EN
        // Long stall without watchdog: waits forever, late ack still completes.
        begin
            int bad = 0;
            wait_ready(1'b0, "stall");
            tp_valid = 1'b1;
            tp_data  = 4'b0101;
            sb_q.push_back(8'b01_01_10_01);
            tp_acc_exp++;
            tick(1);
            tp_valid = 1'b0;
            sb_check("stall dr", tp_dr);
            for (int c = 0; c < 5000; c++) begin
                tick(1);
                if (tp_timeout !== 1'b0 || tp_busy !== 1'b1) bad++;
            end
            chk("stall cycles_bad", bad, 0);
            chk("stall dr_held", tp_dr, 8'b01_01_10_01);
            tp_ack = ~tp_ack;
            tick(3);
            chk("stall done_busy", tp_busy, 0);
            chk("stall done_ready", tp_ready, 1);
        end
`endif

        chk("fp accept_count", fp_acc, fp_acc_exp);
        chk("tp accept_count", tp_acc, tp_acc_exp);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
